// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ byte
// producers, with an inter-frame idle gap and a tx_done watchdog.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | waiting for a valid requester and an idle transmitter
// ST_ISSUE     | one-cycle tx_start, watchdog cleared
// ST_WAIT_DONE | frame in flight, watchdog counting towards abort
// ST_GAP       | enforced idle gap, requests ignored
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GAP_CLKS     = 16,
    parameter int TIMEOUT_CLKS = 20000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         req_done,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_done,
    input  logic                       tx_active,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT_CLKS);
    // GAP_CLKS = 0 would give a zero-width counter; keep one unused bit instead.
    localparam int GW  = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CLKS - 1);
    localparam logic [GW-1:0]  GAP_LAST = (GAP_CLKS > 0) ? GW'(GAP_CLKS - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] winner;
    logic           found;
    logic [7:0]     winner_data;
    logic           accept;
    logic           frame_end;
    logic           wd_expire;
    logic [WDW-1:0] wd_cnt;
    logic [GW-1:0]  gap_cnt;

    // Round-robin search: first valid index after the last grant, wrapping.
    always_comb begin
        logic [IDW-1:0] cand;
        found       = 1'b0;
        winner      = '0;
        winner_data = 8'h00;
        cand        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDW'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == IDW'(i)) begin
                winner_data = req_data[8*i +: 8];
            end
        end
    end

    assign accept    = (state == ST_IDLE) && found && !tx_active;
    assign frame_end = (state == ST_WAIT_DONE) && (tx_done || (wd_cnt == WD_LAST));
    // tx_done on the expiry cycle counts as a normal completion.
    assign wd_expire = (state == ST_WAIT_DONE) && !tx_done && (wd_cnt == WD_LAST);

    // Combinational handshake and status outputs; ready is held low while in reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && !rst && (winner == IDW'(i));
        end
        tx_start = (state == ST_ISSUE);
        busy     = (state != ST_IDLE);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (frame_end) begin
                    state_nxt = (GAP_CLKS > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the winning byte and index at the accept edge; held until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data    <= 8'h00;
            grant_id   <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
        end else if (accept) begin
            tx_data    <= winner_data;
            grant_id   <= winner;
            last_grant <= winner;
        end
    end

    // Watchdog: cleared at issue, counts up while waiting, saturates at its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wd_cnt <= '0;
        end else if ((state == ST_WAIT_DONE) && (wd_cnt != WD_LAST)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Gap timer: loaded at frame end, counts down to zero through the gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (frame_end) begin
            gap_cnt <= GAP_LAST;
        end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - 1'b1;
        end
    end

    // Completion and abort pulses, one cycle after the frame ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_done    <= '0;
            timeout_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_done[i] <= frame_end && (grant_id == IDW'(i));
            end
            timeout_err <= wd_expire;
        end
    end

endmodule
